// File: rtl/hw_dec.sv
// Decryption core for the 128-bit lightweight block cipher on a 32-bit Avalon-MM slave port.
// Optional cached-key mode is compiled in with HW_DEC_KEYREUSE_EN.
module hw_dec #(
    parameter int unsigned ROUNDS = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest
);

    localparam logic [3:0] RLAST = 4'(ROUNDS - 1);

    typedef enum logic [2:0] {IDLE, KEY, EXPAND, ROUND, OUT} state_t;

    state_t       state, state_n;
    logic [1:0]   wcnt, wcnt_n;
    logic [3:0]   rcnt, rcnt_n;
    logic [127:0] text, text_n;
    logic [127:0] k, k_n;
    logic [31:0]  readdata_n;
    logic         wait_n;

`ifdef HW_DEC_KEYREUSE_EN
    logic [127:0] kc, kc_n;
    logic         kcv, kcv_n;
    logic         reuse, reuse_n;
`endif

    logic [63:0]  b, dn, c, l, h, t;
    logic [127:0] k_fwd, k_bwd;
    logic [6:0]   rc;

    function automatic logic [63:0] swap64(input logic [63:0] x);
        return {x[47:32], x[63:48], x[15:0], x[31:16]};
    endfunction

    // Inverse of the PRESENT 4-bit S-box, applied to every nibble.
    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [31:0] inv_sbox32(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            y[4*i +: 4] = inv_sbox4(x[4*i +: 4]);
        end
        return y;
    endfunction

    function automatic logic [6:0] rc7(input logic [3:0] r);
        logic [6:0] v;
        case (r)
            4'd0:  v = 7'h5A;  4'd1:  v = 7'h34;  4'd2:  v = 7'h73;  4'd3:  v = 7'h66;
            4'd4:  v = 7'h57;  4'd5:  v = 7'h35;  4'd6:  v = 7'h71;  4'd7:  v = 7'h62;
            4'd8:  v = 7'h5F;  4'd9:  v = 7'h25;  4'd10: v = 7'h51;  4'd11: v = 7'h22;
            default: v = 7'h00;
        endcase
        return v;
    endfunction

    // Round and key-schedule datapath
    always_comb begin
        rc    = rc7(rcnt);
        b     = text[63:0];
        dn    = text[127:64] ^ b;
        c     = swap64({dn[20:0], dn[63:21]});
        l     = c ^ k[63:0];
        l[20:14] = l[20:14] ^ rc;
        h     = {inv_sbox32(b[63:32]), inv_sbox32(b[31:0])} ^ k[127:64];
        t     = swap64(k[63:0]);
        k_fwd = {t, t ^ k[127:64]};
        k_bwd = {k[127:64] ^ k[63:0], swap64(k[127:64])};
    end

    always_comb begin
        state_n    = state;
        wcnt_n     = wcnt;
        rcnt_n     = rcnt;
        text_n     = text;
        k_n        = k;
        readdata_n = '0;
`ifdef HW_DEC_KEYREUSE_EN
        kc_n       = kc;
        kcv_n      = kcv;
        reuse_n    = reuse;
`endif
        case (state)
            IDLE: begin
                if (write) begin
                    text_n[{wcnt, 5'b0} +: 32] = writedata;
                    wcnt_n = wcnt + 2'd1;
                    if (wcnt == 2'd3) begin
                        state_n = KEY;
`ifdef HW_DEC_KEYREUSE_EN
                        if (address) begin
                            state_n = ROUND;
                            rcnt_n  = RLAST;
                            k_n     = kc;
                            reuse_n = 1'b1;
                        end
`endif
                    end
                end
            end
            KEY: begin
                if (write) begin
                    k_n[{wcnt, 5'b0} +: 32] = writedata;
                    wcnt_n = wcnt + 2'd1;
                    if (wcnt == 2'd3) begin
                        if (address) begin
                            state_n = EXPAND;
                            rcnt_n  = RLAST;
`ifdef HW_DEC_KEYREUSE_EN
                            reuse_n = 1'b0;
`endif
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            EXPAND: begin
                k_n = k_fwd;
                if (rcnt == 4'd0) begin
                    state_n = ROUND;
                    rcnt_n  = RLAST;
`ifdef HW_DEC_KEYREUSE_EN
                    kc_n    = k_fwd;
                    kcv_n   = 1'b1;
`endif
                end else begin
                    rcnt_n = rcnt - 4'd1;
                end
            end
            ROUND: begin
                text_n = {h, l};
                k_n    = k_bwd;
                if (rcnt == 4'd0) begin
                    state_n = OUT;
                    wcnt_n  = 2'd0;
`ifdef HW_DEC_KEYREUSE_EN
                    if (reuse && !kcv) text_n = '0;
`endif
                end else begin
                    rcnt_n = rcnt - 4'd1;
                end
            end
            OUT: begin
                // A write abandons the pending reads and becomes ciphertext word 0.
                if (write) begin
                    text_n[31:0] = writedata;
                    wcnt_n  = 2'd1;
                    state_n = IDLE;
                end else if (read) begin
                    readdata_n = text[{wcnt, 5'b0} +: 32];
                    wcnt_n = wcnt + 2'd1;
                    if (wcnt == 2'd3) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        wait_n = (state_n == EXPAND) || (state_n == ROUND);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wcnt        <= '0;
            rcnt        <= '0;
            text        <= '0;
            k           <= '0;
            readdata    <= '0;
            waitrequest <= 1'b0;
`ifdef HW_DEC_KEYREUSE_EN
            kc          <= '0;
            kcv         <= 1'b0;
            reuse       <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            wcnt        <= wcnt_n;
            rcnt        <= rcnt_n;
            text        <= text_n;
            k           <= k_n;
            readdata    <= readdata_n;
            waitrequest <= wait_n;
`ifdef HW_DEC_KEYREUSE_EN
            kc          <= kc_n;
            kcv         <= kcv_n;
            reuse       <= reuse_n;
`endif
        end
    end

endmodule

// File: tb/tb_hw_dec.sv
// Bench for hw_dec: a forward-cipher model produces ciphertext; expected plaintext words are queued
// when a block is sent and compared as the core returns them.
module tb_hw_dec;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, address, write, read, sel;
    logic [31:0] writedata;
    logic        write0, read0, write1, read1;
    logic [31:0] rdata0, rdata1, rd_obs;
    logic        wait0, wait1, wr_obs;

    assign write0 = write & ~sel;
    assign read0  = read  & ~sel;
    assign write1 = write &  sel;
    assign read1  = read  &  sel;
    assign rd_obs = sel ? rdata1 : rdata0;
    assign wr_obs = sel ? wait1  : wait0;

    hw_dec #(.ROUNDS(12)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write0),
        .writedata(writedata), .read(read0), .readdata(rdata0), .waitrequest(wait0)
    );

    hw_dec #(.ROUNDS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write1),
        .writedata(writedata), .read(read1), .readdata(rdata1), .waitrequest(wait1)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic         stall;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [31:0] sbox32(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] swp(input logic [63:0] x);
        return {x[47:32], x[63:48], x[15:0], x[31:16]};
    endfunction

    function automatic logic [6:0] rcon(input int r);
        logic [6:0] v;
        case (r)
            0: v = 7'h5A;  1: v = 7'h34;  2: v = 7'h73;  3: v = 7'h66;
            4: v = 7'h57;  5: v = 7'h35;  6: v = 7'h71;  7: v = 7'h62;
            8: v = 7'h5F;  9: v = 7'h25; 10: v = 7'h51; default: v = 7'h22;
        endcase
        return v;
    endfunction

    // Forward cipher: the inverse of each decrypt round, key stepped forward before use.
    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key, input int rounds);
        logic [127:0] x, kk;
        logic [63:0]  t, bb, cc, dd;
        x  = pt;
        kk = key;
        for (int r = 0; r < rounds; r++) begin
            t  = swp(kk[63:0]);
            kk = {t, t ^ kk[127:64]};
            bb = x[127:64] ^ kk[127:64];
            bb = {sbox32(bb[63:32]), sbox32(bb[31:0])};
            cc = x[63:0] ^ kk[63:0] ^ ({57'd0, rcon(r)} << 14);
            cc = swp(cc);
            dd = {cc[42:0], cc[63:43]};
            x  = {dd ^ bb, bb};
        end
        return x;
    endfunction

    task automatic write_word(input logic a, input logic [31:0] d, input logic rd);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        read      = rd;
        @(posedge clk);
        #1;
        write   = 1'b0;
        read    = 1'b0;
        address = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] ct, input logic [127:0] key,
                              input logic last_addr, input logic first_rd);
        for (int i = 0; i < 4; i++) write_word(1'b0, ct[32*i +: 32], (i == 0) ? first_rd : 1'b0);
        for (int i = 0; i < 4; i++) write_word((i == 3) ? last_addr : 1'b0, key[32*i +: 32], 1'b0);
    endtask

    task automatic push_pt(input logic [127:0] pt);
        for (int i = 0; i < 4; i++) exp_q.push_back(pt[32*i +: 32]);
    endtask

    task automatic wait_busy(input logic stall, output int cyc);
        cyc = 0;
        while (wr_obs && cyc < 1000) begin
            cyc++;
            if (stall) begin
                address   = 1'($urandom);
                writedata = $urandom;
                write     = 1'b1;
                read      = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic read_word(input string name);
        @(negedge clk);
        read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %h expected nothing (queue empty)", name, rd_obs);
        end else begin
            check(name, rd_obs, exp_q.pop_front());
        end
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int rounds,
                             input logic stall, input string name);
        int cyc;
        push_pt(pt);
        send_block(enc(pt, key, rounds), key, 1'b1, 1'b0);
        wait_busy(stall, cyc);
        check({name, " latency"}, 32'(cyc), 32'(2 * rounds));
        for (int i = 0; i < 4; i++) read_word($sformatf("%s word%0d", name, i));
    endtask

    localparam logic [127:0] PT0  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] KEY0 = 128'h00010203_04050607_08090A0B_0C0D0E0F;

    initial begin
        vec_t tv[4];
        int cyc;
        logic [127:0] pt_b;

        tv[0] = '{pt: PT0, key: KEY0, stall: 1'b0};
        tv[1] = '{pt: '0, key: '0, stall: 1'b0};
        tv[2] = '{pt: {128{1'b1}}, key: 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, stall: 1'b0};
        tv[3] = '{pt: PT0, key: KEY0, stall: 1'b1};

        reset_n = 1'b0; address = 1'b0; write = 1'b0; read = 1'b0; sel = 1'b0; writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset waitrequest", {31'd0, wait0}, 32'd0);
        check("reset readdata", rdata0, 32'd0);
        check("reset waitrequest r1", {31'd0, wait1}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        exp_q.push_back(32'd0);
        read_word("idle read");

        for (int i = 0; i < 4; i++) run_block(tv[i].pt, tv[i].key, 12, tv[i].stall, $sformatf("vec%0d", i));

        // Abort on final key write, then a valid block
        send_block(enc(PT0 ^ 128'h5555, KEY0, 12), KEY0, 1'b0, 1'b0);
        check("abort waitrequest", {31'd0, wait0}, 32'd0);
        @(posedge clk); #1;
        check("abort waitrequest later", {31'd0, wait0}, 32'd0);
        exp_q.push_back(32'd0);
        read_word("abort read");
        run_block(PT0 ^ 128'h5555, KEY0, 12, 1'b0, "after abort");

        // Reset in the middle of the inverse rounds
        send_block(enc(PT0, KEY0, 12), KEY0, 1'b1, 1'b0);
        repeat (17) begin @(posedge clk); #1; end
        check("busy before reset", {31'd0, wait0}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midreset waitrequest", {31'd0, wait0}, 32'd0);
        check("midreset readdata", rdata0, 32'd0);
        run_block(128'hA5A5_0F0F_1234_5678_9ABC_DEF0_0000_FFFF, KEY0 ^ {128{1'b1}}, 12, 1'b0, "after reset");

        // Interrupt OUT after two reads; new block's first write also carries a read
        push_pt(PT0);
        send_block(enc(PT0, KEY0, 12), KEY0, 1'b1, 1'b0);
        wait_busy(1'b0, cyc);
        check("intA latency", 32'(cyc), 32'd24);
        read_word("intA word0");
        read_word("intA word1");
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        pt_b = 128'h11112222_33334444_55556666_77778888;
        push_pt(pt_b);
        send_block(enc(pt_b, KEY0, 12), KEY0, 1'b1, 1'b1);
        wait_busy(1'b0, cyc);
        check("intB latency", 32'(cyc), 32'd24);
        for (int i = 0; i < 4; i++) read_word($sformatf("intB word%0d", i));

        // Single-round instance
        sel = 1'b1;
        run_block(PT0, KEY0, 1, 1'b0, "r1");
        run_block(128'hFEEDFACE_0BADF00D_DEADC0DE_8BADF00D, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1, 1'b0, "r1b");
        sel = 1'b0;

        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
